// File: rtl/systolic_array_tile.sv
// Output-stationary ROWS x COLS systolic MAC tile: operand skew, tile sequencing
// (IDLE/FEED/FLUSH/DRAIN) and a row-serial result drain with backpressure.

module systolic_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              sgn_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] w_i,
  output logic [ACC_W-1:0]  acc_o
);
  logic        [2*DATA_W-1:0] prod_u;
  logic signed [2*DATA_W-1:0] prod_s;
  logic        [ACC_W-1:0]    ext, acc_d, acc_q;

  always_comb begin
    prod_u = a_i * w_i;
    prod_s = $signed(a_i) * $signed(w_i);
    if (sgn_i) ext = ACC_W'(prod_s);
    else       ext = ACC_W'(prod_u);
    // Clear wins; operands are zero whenever a clear can happen anyway.
    acc_d = clr_i ? '0 : acc_q + ext;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc_o = acc_q;
endmodule

module systolic_array_tile #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int K_W    = 16,
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [K_W-1:0]         k_len_i,
  input  logic                   accum_i,
  input  logic                   signed_i,
  output logic                   busy_o,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [ROWS*DATA_W-1:0] active_i,
  input  logic [COLS*DATA_W-1:0] weight_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [RW-1:0]          res_row_o,
  output logic [COLS*ACC_W-1:0]  res_data_o,
  output logic                   done_o
);
  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;
  localparam logic [K_W-1:0] FLUSH_LAST = K_W'(ROWS + COLS - 2);

  state_t         state_q, state_d;
  logic [K_W-1:0] k_q, k_d, cnt_q, cnt_d;
  logic           sgn_q, sgn_d, done_q, done_d;
  logic [RW-1:0]  row_q, row_d;
  logic           beat, clr;

  logic [ROWS-1:0][DATA_W-1:0]            a_inj;
  logic [COLS-1:0][DATA_W-1:0]            w_inj;
  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0]  a_g, w_g;
  logic [ROWS-1:0][COLS-1:0][ACC_W-1:0]   acc_w;

  assign beat  = in_valid_i && (state_q == FEED);
  assign clr   = (state_q == IDLE) && start_i && !accum_i;
  // Non-beat cycles push zeros so bubbles and flush never disturb the sums.
  assign a_inj = beat ? active_i : '0;
  assign w_inj = beat ? weight_i : '0;

  for (genvar i = 0; i < ROWS; i++) begin : g_askew
    if (i == 0) begin : g_d0
      assign a_g[0][0] = a_inj[0];
    end else begin : g_dn
      logic [i-1:0][DATA_W-1:0] sr_q;
      always_ff @(posedge clk_i) begin
        if (rst_i) sr_q <= '0;
        else begin
          sr_q[0] <= a_inj[i];
          for (int s = 1; s < i; s++) sr_q[s] <= sr_q[s-1];
        end
      end
      assign a_g[i][0] = sr_q[i-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_wskew
    if (j == 0) begin : g_d0
      assign w_g[0][0] = w_inj[0];
    end else begin : g_dn
      logic [j-1:0][DATA_W-1:0] sr_q;
      always_ff @(posedge clk_i) begin
        if (rst_i) sr_q <= '0;
        else begin
          sr_q[0] <= w_inj[j];
          for (int s = 1; s < j; s++) sr_q[s] <= sr_q[s-1];
        end
      end
      assign w_g[0][j] = sr_q[j-1];
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      if (j > 0) begin : g_ah
        logic [DATA_W-1:0] a_q;
        always_ff @(posedge clk_i) begin
          if (rst_i) a_q <= '0;
          else       a_q <= a_g[i][j-1];
        end
        assign a_g[i][j] = a_q;
      end
      if (i > 0) begin : g_wv
        logic [DATA_W-1:0] w_q;
        always_ff @(posedge clk_i) begin
          if (rst_i) w_q <= '0;
          else       w_q <= w_g[i-1][j];
        end
        assign w_g[i][j] = w_q;
      end
      systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clr),
        .sgn_i (sgn_q),
        .a_i   (a_g[i][j]),
        .w_i   (w_g[i][j]),
        .acc_o (acc_w[i][j])
      );
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    row_d   = row_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (start_i) begin
        k_d     = k_len_i;
        sgn_d   = signed_i;
        cnt_d   = '0;
        row_d   = '0;
        state_d = (k_len_i != '0) ? FEED : DRAIN;
      end
      FEED: if (beat) begin
        if (cnt_q == k_q - K_W'(1)) begin
          cnt_d   = '0;
          state_d = FLUSH;
        end else cnt_d = cnt_q + K_W'(1);
      end
      // Long enough for the last beat to reach PE(ROWS-1,COLS-1).
      FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else cnt_d = cnt_q + K_W'(1);
      end
      DRAIN: if (res_ready_i) begin
        if (row_q == RW'(ROWS - 1)) begin
          row_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else row_d = row_q + RW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign in_ready_o  = (state_q == FEED);
  assign res_valid_o = (state_q == DRAIN);
  assign res_row_o   = row_q;
  assign res_data_o  = (state_q == DRAIN) ? acc_w[row_q] : '0;
  assign done_o      = done_q;
endmodule

// File: tb/tb_systolic_array_tile.sv
// Randomized bench for systolic_array_tile: a sum-of-products reference model
// checks a 32-bit and a 16-bit accumulator instance driven in parallel.
module tb_systolic_array_tile;
  localparam int R = 4, C = 4, DW = 8, AW = 32, KW = 16;

  logic clk = 1'b0;
  logic rst_i, start_i, accum_i, signed_i, in_valid_i, res_ready_i;
  logic [KW-1:0]   k_len_i;
  logic [R*DW-1:0] active_i;
  logic [C*DW-1:0] weight_i;
  logic busy_o, in_ready_o, res_valid_o, done_o;
  logic [1:0] res_row_o;
  logic [C*AW-1:0] res_data_o;
  logic busy16, in_ready16, res_valid16, done16;
  logic [1:0] res_row16;
  logic [C*16-1:0] res_data16;

  int checks = 0, errors = 0;
  logic [7:0]  av[64][R];
  logic [7:0]  wv[64][C];
  logic [31:0] acc_m[R][C];

  always #5 clk = ~clk;

  systolic_array_tile #(.DATA_W(DW), .ACC_W(AW), .ROWS(R), .COLS(C), .K_W(KW)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .k_len_i(k_len_i), .accum_i(accum_i),
    .signed_i(signed_i), .busy_o(busy_o), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .active_i(active_i), .weight_i(weight_i), .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i), .res_row_o(res_row_o), .res_data_o(res_data_o), .done_o(done_o));

  systolic_array_tile #(.DATA_W(DW), .ACC_W(16), .ROWS(R), .COLS(C), .K_W(KW)) dut16 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .k_len_i(k_len_i), .accum_i(accum_i),
    .signed_i(signed_i), .busy_o(busy16), .in_valid_i(in_valid_i), .in_ready_o(in_ready16),
    .active_i(active_i), .weight_i(weight_i), .res_valid_o(res_valid16),
    .res_ready_i(res_ready_i), .res_row_o(res_row16), .res_data_o(res_data16), .done_o(done16));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // mode 0: random, 1: ramp actives with identity weights, 2: constants
  function automatic void fill(input int k, input int mode, input logic [7:0] ca, input logic [7:0] cw);
    for (int b = 0; b < k; b++) begin
      for (int i = 0; i < R; i++)
        av[b][i] = (mode == 0) ? 8'($urandom) : (mode == 1) ? 8'(i + b) : ca;
      for (int j = 0; j < C; j++)
        wv[b][j] = (mode == 0) ? 8'($urandom) : (mode == 1) ? ((b == j) ? 8'd1 : 8'd0) : cw;
    end
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) acc_m[i][j] = '0;
  endfunction

  function automatic void model(input int k, input bit acc, input bit sg);
    byte sa, sw;
    int  p;
    if (!acc) clear_model();
    for (int b = 0; b < k; b++)
      for (int i = 0; i < R; i++)
        for (int j = 0; j < C; j++) begin
          sa = av[b][i];
          sw = wv[b][j];
          if (sg) p = int'(sa) * int'(sw);
          else    p = int'(av[b][i]) * int'(wv[b][j]);
          acc_m[i][j] = acc_m[i][j] + 32'(p);
        end
  endfunction

  task automatic run_tile(input int k, input bit acc, input bit sg, input bit bubbles,
                          input int bp_row, input bit poke);
    int cyc, b, g;
    bit rdy, tog;
    logic [127:0] e;
    logic [63:0]  e16;
    model(k, acc, sg);
    @(posedge clk); #1;
    start_i = 1'b1; k_len_i = KW'(k); accum_i = acc; signed_i = sg;
    @(posedge clk); #1;
    start_i = 1'b0; accum_i = ~acc; signed_i = ~sg; k_len_i = 16'($urandom);
    cyc = 1; b = 0; g = 0; tog = 1'b1;
    while (b < k && g < 200) begin
      in_valid_i = bubbles ? tog : 1'b1;
      tog = ~tog;
      if (in_valid_i) begin
        for (int i = 0; i < R; i++) active_i[i*DW +: DW] = av[b][i];
        for (int j = 0; j < C; j++) weight_i[j*DW +: DW] = wv[b][j];
      end else begin
        active_i = $urandom;
        weight_i = $urandom;
      end
      if (poke && b == 1) begin start_i = 1'b1; k_len_i = 16'd1; accum_i = 1'b0; end
      @(negedge clk); rdy = in_ready_o;
      @(posedge clk); #1;
      start_i = 1'b0;
      if (in_valid_i && rdy) b++;
      cyc++; g++;
    end
    in_valid_i = 1'b0; active_i = $urandom; weight_i = $urandom;
    chk("feed_beats", b, k);
    res_ready_i = 1'b0;
    @(negedge clk);
    chk("post_feed_ready", {in_ready_o, in_ready16}, 2'b00);
    chk("post_feed_busy", busy_o, 1'b1);
    g = 0;
    while (!res_valid_o && g < 200) begin
      @(posedge clk); #1; cyc++; g++;
      @(negedge clk);
    end
    chk("valid_timeout", res_valid_o, 1'b1);
    if (!bubbles) chk("latency", cyc, (k == 0) ? 1 : k + R + C);
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        e[c*32 +: 32]   = acc_m[r][c];
        e16[c*16 +: 16] = acc_m[r][c][15:0];
      end
      if (r == bp_row) repeat (5) begin
        chk("stall_row", res_row_o, r);
        chk("stall_data", res_data_o, e);
        @(posedge clk); #1;
        @(negedge clk);
      end
      chk("row", res_row_o, r);
      chk("valid", {res_valid_o, res_valid16}, 2'b11);
      chk("data", res_data_o, e);
      chk("row16", res_row16, r);
      chk("data16", res_data16, e16);
      chk("done_early", done_o, 1'b0);
      res_ready_i = 1'b1;
      if (poke && r == 0) start_i = 1'b1;
      @(posedge clk); #1;
      res_ready_i = 1'b0; start_i = 1'b0;
      @(negedge clk);
    end
    chk("done", {done_o, done16}, 2'b11);
    chk("idle_busy", {busy_o, busy16}, 2'b00);
    chk("idle_valid", res_valid_o, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_pulse", done_o, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; start_i = 1'b0; k_len_i = '0; accum_i = 1'b0; signed_i = 1'b0;
    in_valid_i = 1'b0; res_ready_i = 1'b0; active_i = '0; weight_i = '0;
    clear_model();
    repeat (3) @(posedge clk);
    #1; rst_i = 1'b0;
    @(negedge clk);
    chk("rst_flags", {busy_o, in_ready_o, res_valid_o, done_o}, 4'b0000);
    chk("rst_row", res_row_o, 2'd0);
    chk("rst_data", res_data_o, '0);

    fill(4, 1, 8'd0, 8'd0);   run_tile(4, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    fill(4, 1, 8'd0, 8'd0);   run_tile(4, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    fill(1, 2, 8'hFF, 8'h02); run_tile(1, 1'b0, 1'b1, 1'b0, -1, 1'b0);
    fill(1, 2, 8'hFF, 8'h02); run_tile(1, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    fill(2, 2, 8'd1, 8'd1);   run_tile(2, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    fill(3, 2, 8'd1, 8'd1);   run_tile(3, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    run_tile(0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    fill(2, 2, 8'hFF, 8'hFF); run_tile(2, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    fill(6, 0, 8'd0, 8'd0);   run_tile(6, 1'b0, 1'b1, 1'b0, 1, 1'b0);
    fill(5, 0, 8'd0, 8'd0);   run_tile(5, 1'b1, 1'b0, 1'b0, -1, 1'b1);

    // Reset partway through FEED abandons the tile and zeroes the array.
    @(posedge clk); #1;
    start_i = 1'b1; k_len_i = 16'd4; accum_i = 1'b1; signed_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (2) begin
      in_valid_i = 1'b1; active_i = $urandom; weight_i = $urandom;
      @(posedge clk); #1;
    end
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0; in_valid_i = 1'b0;
    @(negedge clk);
    chk("midrst_flags", {busy_o, in_ready_o, res_valid_o, done_o}, 4'b0000);
    chk("midrst_row", res_row_o, 2'd0);
    chk("midrst_data", res_data_o, '0);
    clear_model();
    run_tile(0, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    fill(3, 0, 8'd0, 8'd0); run_tile(3, 1'b0, 1'b1, 1'b0, -1, 1'b0);

    for (int t = 0; t < 6; t++) begin
      int k;
      k = $urandom_range(0, 20);
      fill(k, 0, 8'd0, 8'd0);
      run_tile(k, 1'($urandom), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 1) != 0) ? $urandom_range(0, R-1) : -1, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
